// File: rtl/l15_req_arbiter.sv
// l15_req_arbiter: shares the L1.5 transducer port between IFU and LSU, one transaction outstanding.
// Latency: grant -> transducer_l15_val 1 cycle; req_ack combinational with header_ack; resp_val 1 cycle after the L1.5 return.
// Backpressure: requesters hold req_val/payload until req_ack; L1.5 returns are always consumed in the cycle they arrive.
//
// Ports:
//   clk, nrst                      clock, asynchronous active-low reset
//   ifu_* / lsu_*  (in)            request valid + payload (rqtype, size, address, data)
//   ifu_* / lsu_*  (out)           req_ack, one-cycle resp_val, resp_err (timeout) qualified by resp_val
//   resp_data_0/1, resp_returntype shared response payload, valid with either resp_val
//   transducer_l15_*               request channel towards L1.5 (val + registered payload), req_ack for returns
//   l15_transducer_*               header_ack and return channel from L1.5
//   irq_evt                        one-cycle pulse when an unsolicited interrupt return is absorbed
module l15_req_arbiter #(
    parameter bit          FIXED_PRIO  = 1'b0,
    parameter logic [4:0]  INT_RETTYPE = 5'b00111,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        nrst,

    input  logic        ifu_req_val,
    input  logic [4:0]  ifu_rqtype,
    input  logic [2:0]  ifu_size,
    input  logic [31:0] ifu_address,
    input  logic [63:0] ifu_data,
    input  logic        lsu_req_val,
    input  logic [4:0]  lsu_rqtype,
    input  logic [2:0]  lsu_size,
    input  logic [31:0] lsu_address,
    input  logic [63:0] lsu_data,

    output logic        ifu_req_ack,
    output logic        lsu_req_ack,
    output logic        ifu_resp_val,
    output logic        lsu_resp_val,
    output logic        ifu_resp_err,
    output logic        lsu_resp_err,
    output logic [63:0] resp_data_0,
    output logic [63:0] resp_data_1,
    output logic [4:0]  resp_returntype,

    output logic        transducer_l15_val,
    output logic [4:0]  transducer_l15_rqtype,
    output logic [2:0]  transducer_l15_size,
    output logic [31:0] transducer_l15_address,
    output logic [63:0] transducer_l15_data,
    input  logic        l15_transducer_header_ack,

    input  logic        l15_transducer_val,
    input  logic [63:0] l15_transducer_data_0,
    input  logic [63:0] l15_transducer_data_1,
    input  logic [4:0]  l15_transducer_returntype,
    output logic        transducer_l15_req_ack,

    output logic        irq_evt
);

    typedef struct packed {
        logic [4:0]  rqtype;
        logic [2:0]  size;
        logic [31:0] address;
        logic [63:0] data;
    } req_t;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] REQ       = 2'd1;
    localparam logic [1:0] WAIT_RESP = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    // Watchdog only needs to count up to TIMEOUT-1.
    localparam int unsigned     WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    logic [1:0]      state;
    logic            gnt;        // 0 = IFU, 1 = LSU
    logic            last_gnt;   // 0 = IFU, 1 = LSU
    req_t            req_q;
    req_t            ifu_req;
    req_t            lsu_req;
    logic [WD_W-1:0] wd_cnt;
    logic            is_irq;
    logic            sol_resp;
    logic            wd_expire;
    logic            pick_lsu;

    assign ifu_req = {ifu_rqtype, ifu_size, ifu_address, ifu_data};
    assign lsu_req = {lsu_rqtype, lsu_size, lsu_address, lsu_data};

    // Every return is classified on its own: interrupt returns are absorbed,
    // anything else is a solicited response (only meaningful in WAIT_RESP).
    assign is_irq    = l15_transducer_val && (l15_transducer_returntype == INT_RETTYPE);
    assign sol_resp  = l15_transducer_val && !is_irq;
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

    // On a tie the round-robin winner is whoever was not granted last;
    // last_gnt resets to LSU so the IFU wins the first tie.
    always_comb begin
        pick_lsu = lsu_req_val;
        if (ifu_req_val && lsu_req_val) begin
            pick_lsu = FIXED_PRIO ? 1'b0 : ~last_gnt;
        end
    end

    assign transducer_l15_val     = (state == REQ);
    assign transducer_l15_rqtype  = req_q.rqtype;
    assign transducer_l15_size    = req_q.size;
    assign transducer_l15_address = req_q.address;
    assign transducer_l15_data    = req_q.data;

    assign ifu_req_ack = (state == REQ) && l15_transducer_header_ack && !gnt;
    assign lsu_req_ack = (state == REQ) && l15_transducer_header_ack &&  gnt;

    // Returns are never back-pressured; stray ones outside WAIT_RESP are
    // acked here and simply not forwarded.
    assign transducer_l15_req_ack = l15_transducer_val;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= IDLE;
            gnt             <= 1'b0;
            last_gnt        <= 1'b1;
            req_q           <= '0;
            wd_cnt          <= '0;
            resp_data_0     <= '0;
            resp_data_1     <= '0;
            resp_returntype <= '0;
            ifu_resp_val    <= 1'b0;
            lsu_resp_val    <= 1'b0;
            ifu_resp_err    <= 1'b0;
            lsu_resp_err    <= 1'b0;
            irq_evt         <= 1'b0;
        end else begin
            irq_evt      <= is_irq;
            // resp_val/resp_err are raised on entry to RESP and so last
            // exactly the one RESP cycle.
            ifu_resp_val <= 1'b0;
            lsu_resp_val <= 1'b0;
            ifu_resp_err <= 1'b0;
            lsu_resp_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (ifu_req_val || lsu_req_val) begin
                        gnt      <= pick_lsu;
                        last_gnt <= pick_lsu;
                        req_q    <= pick_lsu ? lsu_req : ifu_req;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (l15_transducer_header_ack) begin
                        state <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (sol_resp) begin
                        resp_data_0     <= l15_transducer_data_0;
                        resp_data_1     <= l15_transducer_data_1;
                        resp_returntype <= l15_transducer_returntype;
                        ifu_resp_val    <= !gnt;
                        lsu_resp_val    <=  gnt;
                        state           <= RESP;
                    end else if (wd_expire) begin
                        resp_data_0     <= '0;
                        resp_data_1     <= '0;
                        resp_returntype <= '0;
                        ifu_resp_val    <= !gnt;
                        lsu_resp_val    <=  gnt;
                        ifu_resp_err    <= !gnt;
                        lsu_resp_err    <=  gnt;
                        state           <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    wd_cnt <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l15_req_arbiter.sv
// tb_l15_req_arbiter: checks l15_req_arbiter against a transaction-level model, plus directed scenarios.
// Latency: n/a (testbench).
// Backpressure: bench plays both requesters and the L1.5 side.
module tb_l15_req_arbiter;

    localparam logic [4:0] INT_RT = 5'b00111;
    localparam int         TMO    = 16;

    // Model phases of the single outstanding transaction.
    localparam int P_IDLE = 0;  // nothing in flight
    localparam int P_HDR  = 1;  // request offered to L1.5
    localparam int P_WAIT = 2;  // header accepted, waiting for data
    localparam int P_DLV  = 3;  // response being delivered

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst;
    logic        ifu_req_val, lsu_req_val;
    logic [4:0]  ifu_rqtype, lsu_rqtype;
    logic [2:0]  ifu_size, lsu_size;
    logic [31:0] ifu_address, lsu_address;
    logic [63:0] ifu_data, lsu_data;
    logic        l15_transducer_header_ack, l15_transducer_val;
    logic [63:0] l15_transducer_data_0, l15_transducer_data_1;
    logic [4:0]  l15_transducer_returntype;

    logic        ifu_req_ack, lsu_req_ack, ifu_resp_val, lsu_resp_val, ifu_resp_err, lsu_resp_err;
    logic [63:0] resp_data_0, resp_data_1;
    logic [4:0]  resp_returntype;
    logic        transducer_l15_val, transducer_l15_req_ack, irq_evt;
    logic [4:0]  transducer_l15_rqtype;
    logic [2:0]  transducer_l15_size;
    logic [31:0] transducer_l15_address;
    logic [63:0] transducer_l15_data;

    logic        fp_ifu_req_ack, fp_lsu_req_ack, fp_ifu_resp_val, fp_lsu_resp_val, fp_ifu_resp_err, fp_lsu_resp_err;
    logic [63:0] fp_resp_data_0, fp_resp_data_1;
    logic [4:0]  fp_resp_returntype;
    logic        fp_transducer_l15_val, fp_transducer_l15_req_ack, fp_irq_evt;
    logic [4:0]  fp_transducer_l15_rqtype;
    logic [2:0]  fp_transducer_l15_size;
    logic [31:0] fp_transducer_l15_address;
    logic [63:0] fp_transducer_l15_data;

    l15_req_arbiter #(.FIXED_PRIO(1'b0), .INT_RETTYPE(INT_RT), .TIMEOUT(TMO)) dut (
        .clk(clk), .nrst(nrst),
        .ifu_req_val(ifu_req_val), .ifu_rqtype(ifu_rqtype), .ifu_size(ifu_size),
        .ifu_address(ifu_address), .ifu_data(ifu_data),
        .lsu_req_val(lsu_req_val), .lsu_rqtype(lsu_rqtype), .lsu_size(lsu_size),
        .lsu_address(lsu_address), .lsu_data(lsu_data),
        .ifu_req_ack(ifu_req_ack), .lsu_req_ack(lsu_req_ack),
        .ifu_resp_val(ifu_resp_val), .lsu_resp_val(lsu_resp_val),
        .ifu_resp_err(ifu_resp_err), .lsu_resp_err(lsu_resp_err),
        .resp_data_0(resp_data_0), .resp_data_1(resp_data_1), .resp_returntype(resp_returntype),
        .transducer_l15_val(transducer_l15_val), .transducer_l15_rqtype(transducer_l15_rqtype),
        .transducer_l15_size(transducer_l15_size), .transducer_l15_address(transducer_l15_address),
        .transducer_l15_data(transducer_l15_data),
        .l15_transducer_header_ack(l15_transducer_header_ack),
        .l15_transducer_val(l15_transducer_val),
        .l15_transducer_data_0(l15_transducer_data_0), .l15_transducer_data_1(l15_transducer_data_1),
        .l15_transducer_returntype(l15_transducer_returntype),
        .transducer_l15_req_ack(transducer_l15_req_ack), .irq_evt(irq_evt)
    );

    l15_req_arbiter #(.FIXED_PRIO(1'b1), .INT_RETTYPE(INT_RT), .TIMEOUT(TMO)) dut_fp (
        .clk(clk), .nrst(nrst),
        .ifu_req_val(ifu_req_val), .ifu_rqtype(ifu_rqtype), .ifu_size(ifu_size),
        .ifu_address(ifu_address), .ifu_data(ifu_data),
        .lsu_req_val(lsu_req_val), .lsu_rqtype(lsu_rqtype), .lsu_size(lsu_size),
        .lsu_address(lsu_address), .lsu_data(lsu_data),
        .ifu_req_ack(fp_ifu_req_ack), .lsu_req_ack(fp_lsu_req_ack),
        .ifu_resp_val(fp_ifu_resp_val), .lsu_resp_val(fp_lsu_resp_val),
        .ifu_resp_err(fp_ifu_resp_err), .lsu_resp_err(fp_lsu_resp_err),
        .resp_data_0(fp_resp_data_0), .resp_data_1(fp_resp_data_1), .resp_returntype(fp_resp_returntype),
        .transducer_l15_val(fp_transducer_l15_val), .transducer_l15_rqtype(fp_transducer_l15_rqtype),
        .transducer_l15_size(fp_transducer_l15_size), .transducer_l15_address(fp_transducer_l15_address),
        .transducer_l15_data(fp_transducer_l15_data),
        .l15_transducer_header_ack(l15_transducer_header_ack),
        .l15_transducer_val(l15_transducer_val),
        .l15_transducer_data_0(l15_transducer_data_0), .l15_transducer_data_1(l15_transducer_data_1),
        .l15_transducer_returntype(l15_transducer_returntype),
        .transducer_l15_req_ack(fp_transducer_l15_req_ack), .irq_evt(fp_irq_evt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int          m_phase;
    int          m_owner;    // 0 = IFU, 1 = LSU
    int          m_last;
    int          m_waited;   // cycles spent waiting for data
    logic        m_err, m_irq, m_rt_known;
    logic [63:0] m_d0, m_d1;
    logic [4:0]  m_rt;
    logic [4:0]  m_rqtype;
    logic [2:0]  m_size;
    logic [31:0] m_addr;
    logic [63:0] m_data;

    task automatic model_reset();
        m_phase = P_IDLE; m_owner = 0; m_last = 1; m_waited = 0;
        m_err = 1'b0; m_irq = 1'b0; m_rt_known = 1'b1;
        m_d0 = '0; m_d1 = '0; m_rt = '0;
        m_rqtype = '0; m_size = '0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_compare();
        logic dlv;
        dlv = (m_phase == P_DLV);
        check("l15_val",     64'(transducer_l15_val), 64'(m_phase == P_HDR));
        check("l15_rqtype",  64'(transducer_l15_rqtype), 64'(m_rqtype));
        check("l15_size",    64'(transducer_l15_size), 64'(m_size));
        check("l15_address", 64'(transducer_l15_address), 64'(m_addr));
        check("l15_data",    transducer_l15_data, m_data);
        check("ifu_req_ack", 64'(ifu_req_ack), 64'(m_phase == P_HDR && l15_transducer_header_ack && m_owner == 0));
        check("lsu_req_ack", 64'(lsu_req_ack), 64'(m_phase == P_HDR && l15_transducer_header_ack && m_owner == 1));
        check("ifu_resp_val", 64'(ifu_resp_val), 64'(dlv && m_owner == 0));
        check("lsu_resp_val", 64'(lsu_resp_val), 64'(dlv && m_owner == 1));
        check("ifu_resp_err", 64'(ifu_resp_err), 64'(dlv && m_owner == 0 && m_err));
        check("lsu_resp_err", 64'(lsu_resp_err), 64'(dlv && m_owner == 1 && m_err));
        check("resp_data_0", resp_data_0, m_d0);
        check("resp_data_1", resp_data_1, m_d1);
        if (m_rt_known) check("resp_returntype", 64'(resp_returntype), 64'(m_rt));
        check("l15_req_ack", 64'(transducer_l15_req_ack), 64'(l15_transducer_val));
        check("irq_evt",     64'(irq_evt), 64'(m_irq));
    endtask

    task automatic model_advance();
        logic irq, sol;
        int   win;
        irq   = l15_transducer_val && (l15_transducer_returntype == INT_RT);
        sol   = l15_transducer_val && !irq;
        m_irq = irq;
        case (m_phase)
            P_IDLE: if (ifu_req_val || lsu_req_val) begin
                if (ifu_req_val && lsu_req_val) win = 1 - m_last;
                else                            win = lsu_req_val ? 1 : 0;
                m_owner = win;
                m_last  = win;
                if (win == 0) begin
                    m_rqtype = ifu_rqtype; m_size = ifu_size; m_addr = ifu_address; m_data = ifu_data;
                end else begin
                    m_rqtype = lsu_rqtype; m_size = lsu_size; m_addr = lsu_address; m_data = lsu_data;
                end
                m_phase = P_HDR;
            end
            P_HDR: if (l15_transducer_header_ack) begin
                m_phase  = P_WAIT;
                m_waited = 0;
            end
            P_WAIT: begin
                m_waited = m_waited + 1;
                if (sol) begin
                    m_d0 = l15_transducer_data_0; m_d1 = l15_transducer_data_1;
                    m_rt = l15_transducer_returntype; m_rt_known = 1'b1;
                    m_err = 1'b0; m_phase = P_DLV;
                end else if (m_waited == TMO) begin
                    m_d0 = '0; m_d1 = '0; m_rt_known = 1'b0;
                    m_err = 1'b1; m_phase = P_DLV;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    // Inputs only change just after posedge, so at negedge they hold the
    // values the DUT will sample on the next edge.
    initial begin : compare_proc
        model_reset();
        forever begin
            @(negedge clk);
            if (!nrst) model_reset();
            else begin
                model_compare();
                model_advance();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!transducer_l15_val && n < 8) begin
            tick();
            n++;
        end
        check({name, "_wait_l15_val"}, 64'(transducer_l15_val), 64'd1);
    endtask

    task automatic give_resp(input logic [4:0] rt, input logic [63:0] d0);
        l15_transducer_val        = 1'b1;
        l15_transducer_returntype = rt;
        l15_transducer_data_0     = d0;
        l15_transducer_data_1     = ~d0;
    endtask

    logic ifu_pend, lsu_pend, ifu_ack_seen, lsu_ack_seen;
    int   r;

    initial begin : stim
        nrst = 1'b0;
        ifu_req_val = 1'b0; lsu_req_val = 1'b0;
        ifu_rqtype = '0; ifu_size = '0; ifu_address = '0; ifu_data = '0;
        lsu_rqtype = '0; lsu_size = '0; lsu_address = '0; lsu_data = '0;
        l15_transducer_header_ack = 1'b0; l15_transducer_val = 1'b0;
        l15_transducer_data_0 = '0; l15_transducer_data_1 = '0; l15_transducer_returntype = '0;
        repeat (3) tick();
        check("rst_l15_val", 64'(transducer_l15_val), 64'd0);
        check("rst_l15_addr", 64'(transducer_l15_address), 64'd0);
        check("rst_resp_val", 64'({ifu_resp_val, lsu_resp_val, irq_evt}), 64'd0);
        nrst = 1'b1;

        // Single IFU load
        ifu_rqtype = 5'h10; ifu_size = 3'd3; ifu_address = 32'h0000_1000; ifu_data = 64'h0;
        ifu_req_val = 1'b1;
        #1 check("t1_val_not_same_cycle", 64'(transducer_l15_val), 64'd0);
        tick();
        check("t1_l15_val", 64'(transducer_l15_val), 64'd1);
        check("t1_addr", 64'(transducer_l15_address), 64'h1000);
        check("t1_rqtype", 64'(transducer_l15_rqtype), 64'h10);
        check("t1_ack_early", 64'(ifu_req_ack), 64'd0);
        tick();
        l15_transducer_header_ack = 1'b1;
        #1;
        check("t1_ifu_req_ack", 64'(ifu_req_ack), 64'd1);
        check("t1_lsu_req_ack", 64'(lsu_req_ack), 64'd0);
        tick();
        l15_transducer_header_ack = 1'b0; ifu_req_val = 1'b0;
        check("t1_val_drop", 64'(transducer_l15_val), 64'd0);
        repeat (4) tick();
        give_resp(5'd0, 64'hDEAD_BEEF_0000_0001);
        #1 check("t1_l15_req_ack", 64'(transducer_l15_req_ack), 64'd1);
        tick();
        l15_transducer_val = 1'b0;
        check("t1_ifu_resp_val", 64'(ifu_resp_val), 64'd1);
        check("t1_resp_data_0", resp_data_0, 64'hDEAD_BEEF_0000_0001);
        check("t1_lsu_resp_val", 64'(lsu_resp_val), 64'd0);
        tick();
        check("t1_resp_one_cycle", 64'(ifu_resp_val), 64'd0);

        // Stray non-interrupt return in IDLE
        give_resp(5'd0, 64'h55);
        #1 check("t6_l15_req_ack", 64'(transducer_l15_req_ack), 64'd1);
        tick();
        l15_transducer_val = 1'b0;
        check("t6_no_resp", 64'({ifu_resp_val, lsu_resp_val}), 64'd0);
        check("t6_no_irq", 64'(irq_evt), 64'd0);
        check("t6_data_kept", resp_data_0, 64'hDEAD_BEEF_0000_0001);

        // Interrupt return during WAIT_RESP
        lsu_rqtype = 5'h00; lsu_size = 3'd2; lsu_address = 32'h0000_2000; lsu_data = 64'h0;
        lsu_req_val = 1'b1;
        wait_req("t3");
        l15_transducer_header_ack = 1'b1;
        #1 check("t3_lsu_req_ack", 64'(lsu_req_ack), 64'd1);
        tick();
        l15_transducer_header_ack = 1'b0; lsu_req_val = 1'b0;
        give_resp(INT_RT, 64'hBAD);
        #1 check("t3_irq_ack", 64'(transducer_l15_req_ack), 64'd1);
        tick();
        l15_transducer_val = 1'b0;
        check("t3_irq_evt", 64'(irq_evt), 64'd1);
        check("t3_no_resp_on_irq", 64'(lsu_resp_val), 64'd0);
        tick();
        check("t3_irq_one_cycle", 64'(irq_evt), 64'd0);
        tick();
        give_resp(5'd0, 64'h1234_5678_9ABC_DEF0);
        #1 check("t3_load_ack", 64'(transducer_l15_req_ack), 64'd1);
        tick();
        l15_transducer_val = 1'b0;
        check("t3_lsu_resp_val", 64'(lsu_resp_val), 64'd1);
        check("t3_ifu_resp_val", 64'(ifu_resp_val), 64'd0);
        check("t3_data", resp_data_0, 64'h1234_5678_9ABC_DEF0);
        tick();

        // Watchdog timeout
        ifu_address = 32'h0000_3000; ifu_req_val = 1'b1;
        wait_req("t4");
        l15_transducer_header_ack = 1'b1;
        tick();
        l15_transducer_header_ack = 1'b0; ifu_req_val = 1'b0;
        repeat (15) tick();
        check("t4_not_early", 64'(ifu_resp_val), 64'd0);
        tick();
        check("t4_resp_val", 64'(ifu_resp_val), 64'd1);
        check("t4_resp_err", 64'(ifu_resp_err), 64'd1);
        check("t4_data", resp_data_0 | resp_data_1, 64'd0);
        check("t4_lsu_quiet", 64'(lsu_resp_val), 64'd0);
        lsu_address = 32'h0000_4000; lsu_req_val = 1'b1;
        wait_req("t4_next");
        l15_transducer_header_ack = 1'b1;
        tick();
        l15_transducer_header_ack = 1'b0; lsu_req_val = 1'b0;
        give_resp(5'd1, 64'h77);
        tick();
        l15_transducer_val = 1'b0;
        check("t4_next_resp", 64'(lsu_resp_val), 64'd1);
        check("t4_next_err", 64'(lsu_resp_err), 64'd0);
        check("t4_next_data", resp_data_0, 64'h77);
        tick();

        // Reset in WAIT_RESP
        ifu_address = 32'h0000_5000; ifu_req_val = 1'b1;
        wait_req("t5");
        l15_transducer_header_ack = 1'b1;
        tick();
        l15_transducer_header_ack = 1'b0; ifu_req_val = 1'b0;
        tick();
        nrst = 1'b0;
        #1;
        check("t5_rst_addr", 64'(transducer_l15_address), 64'd0);
        check("t5_rst_data", resp_data_0, 64'd0);
        check("t5_rst_rt", 64'(resp_returntype), 64'd0);
        tick(); tick();
        ifu_address = 32'h0000_6000; lsu_address = 32'h0000_7000;
        ifu_req_val = 1'b1; lsu_req_val = 1'b1;
        nrst = 1'b1;
        wait_req("t5_after");
        l15_transducer_header_ack = 1'b1;
        #1;
        check("t5_ifu_wins", 64'(ifu_req_ack), 64'd1);
        check("t5_lsu_waits", 64'(lsu_req_ack), 64'd0);
        check("t5_addr", 64'(transducer_l15_address), 64'h6000);
        tick();
        l15_transducer_header_ack = 1'b0; ifu_req_val = 1'b0; lsu_req_val = 1'b0;
        give_resp(5'd2, 64'h99);
        tick();
        l15_transducer_val = 1'b0;
        check("t5_resp", 64'(ifu_resp_val), 64'd1);
        tick();

        // Contention: round-robin vs fixed priority, from reset
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        ifu_address = 32'h0000_8000; lsu_address = 32'h0000_9000;
        ifu_req_val = 1'b1; lsu_req_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_req($sformatf("t2_%0d", i));
            l15_transducer_header_ack = 1'b1;
            #1;
            check($sformatf("t2_rr_ifu_%0d", i), 64'(ifu_req_ack), 64'(i % 2 == 0));
            check($sformatf("t2_rr_lsu_%0d", i), 64'(lsu_req_ack), 64'(i % 2 == 1));
            check($sformatf("t2_fp_ifu_%0d", i), 64'({fp_ifu_req_ack, fp_lsu_req_ack}), 64'b10);
            tick();
            l15_transducer_header_ack = 1'b0;
            give_resp(5'd0, 64'(i));
            tick();
            l15_transducer_val = 1'b0;
            tick();
        end
        ifu_req_val = 1'b0; lsu_req_val = 1'b0;
        tick();

        // Randomized traffic
        ifu_pend = 1'b0; lsu_pend = 1'b0; ifu_ack_seen = 1'b0; lsu_ack_seen = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (ifu_ack_seen) ifu_pend = 1'b0;
            if (!ifu_pend && $urandom_range(0, 99) < 30) begin
                ifu_pend = 1'b1;
                ifu_rqtype = 5'($urandom); ifu_size = 3'($urandom);
                ifu_address = $urandom; ifu_data = {$urandom, $urandom};
            end
            ifu_req_val = ifu_pend;
            if (lsu_ack_seen) lsu_pend = 1'b0;
            if (!lsu_pend && $urandom_range(0, 99) < 30) begin
                lsu_pend = 1'b1;
                lsu_rqtype = 5'($urandom); lsu_size = 3'($urandom);
                lsu_address = $urandom; lsu_data = {$urandom, $urandom};
            end
            lsu_req_val = lsu_pend;

            l15_transducer_header_ack = (m_phase == P_HDR) && ($urandom_range(0, 99) < 40);
            l15_transducer_val        = 1'b0;
            l15_transducer_returntype = 5'd0;
            l15_transducer_data_0     = {$urandom, $urandom};
            l15_transducer_data_1     = {$urandom, $urandom};
            r = $urandom_range(0, 99);
            if (m_phase == P_WAIT && r < 12) begin
                l15_transducer_val = 1'b1;
                do l15_transducer_returntype = 5'($urandom); while (l15_transducer_returntype == INT_RT);
            end else if (r >= 95) begin
                l15_transducer_val        = 1'b1;
                l15_transducer_returntype = INT_RT;
            end else if (m_phase != P_WAIT && r >= 92) begin
                l15_transducer_val = 1'b1;
                do l15_transducer_returntype = 5'($urandom); while (l15_transducer_returntype == INT_RT);
            end
            #1;
            ifu_ack_seen = ifu_req_ack;
            lsu_ack_seen = lsu_req_ack;
            tick();
        end
        ifu_req_val = 1'b0; lsu_req_val = 1'b0;
        l15_transducer_val = 1'b0; l15_transducer_header_ack = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
